// File: rtl/alu_seq_if.sv
// Bus bundle between the command source, the alu_seq sequencer, the ALU and the result consumer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface alu_seq_if #(
   parameter int W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [1:0]       in_op;
   logic [W-1:0]     alu_a;
   logic [W-1:0]     alu_b;
   logic [1:0]       alu_op;
   logic             alu_init;
   logic             alu_done;
   logic [2*W-1:0]   alu_result;
   logic             res_valid;
   logic             res_ready;
   logic [2*W-1:0]   res_data;
   logic             res_err;

   modport slave (
      input  in_valid, in_a, in_b, in_op, alu_done, alu_result, res_ready,
      output in_ready, alu_a, alu_b, alu_op, alu_init, res_valid, res_data, res_err
   );

   modport master (
      output in_valid, in_a, in_b, in_op, alu_done, alu_result, res_ready,
      input  in_ready, alu_a, alu_b, alu_op, alu_init, res_valid, res_data, res_err
   );
endinterface

// File: rtl/alu_seq.sv
// Command sequencer in front of the add/sub/multiply ALU with a held result register.
// Define ALU_SEQ_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog on the multiply wait.
module alu_seq #(
   parameter int W              = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_seq_if.slave  bus
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      EXEC     = 3'd1,
      MUL_INIT = 3'd2,
      MUL_WAIT = 3'd3,
      RESP     = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [2*W-1:0]   data_q, data_d;
   logic             err_q, err_d;
   logic             in_ready_q, res_valid_q, init_q;
   logic             timeout_s;

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q;

   // Watchdog counter: held at zero outside MUL_WAIT so it restarts on every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q != MUL_WAIT) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1'b1);
      end
   end

   assign timeout_s = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state and captured-data logic.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            // in_ready_q gates acceptance so nothing is taken in the first cycle after reset.
            if (bus.in_valid && in_ready_q) begin
               a_d  = bus.in_a;
               b_d  = bus.in_b;
               op_d = bus.in_op;
               case (bus.in_op)
                  2'b00, 2'b01: state_d = EXEC;
                  2'b10:        state_d = MUL_INIT;
                  default: begin
                     state_d = RESP;
                     data_d  = '0;
                     err_d   = 1'b1;
                  end
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            data_d  = bus.alu_result;
            err_d   = 1'b0;
            state_d = RESP;
         end
         MUL_INIT: begin
            state_d = MUL_WAIT;
         end
         MUL_WAIT: begin
            if (bus.alu_done) begin
               data_d  = bus.alu_result;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timeout_s) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               state_d = MUL_WAIT;
            end
         end
         RESP: begin
            if (bus.res_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, operand and result registers; handshake outputs are decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= 2'b00;
         data_q      <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         init_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         data_q      <= data_d;
         err_q       <= err_d;
         in_ready_q  <= (state_d == IDLE);
         res_valid_q <= (state_d == RESP);
         init_q      <= (state_d == MUL_INIT);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_op    = op_q;
   assign bus.alu_init  = init_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = data_q;
   assign bus.res_err   = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized bench for alu_seq with a behavioural ALU and result model.
module tb_alu_seq;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   init_cnt;

   alu_seq_if #(.W(3)) bus ();

   alu_seq #(.W(3), .TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Arithmetic result of a command, as the ALU defines it on a 6-bit bus.
   function automatic logic [5:0] arith(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
      int r;
      case (op)
         2'b00:   r = int'(a) + int'(b);
         2'b01:   r = int'(a) - int'(b);
         2'b10:   r = int'(a) * int'(b);
         default: r = 0;
      endcase
      return 6'(r);
   endfunction

   // ALU stand-in: junk on the bus for reserved op and for an unfinished multiply.
   function automatic logic [5:0] alu_model(input logic [2:0] a, input logic [2:0] b,
                                            input logic [1:0] op, input logic done);
      if (op == 2'b11) return 6'h15;
      if (op == 2'b10 && !done) return 6'h2A;
      return arith(a, b, op);
   endfunction

   assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_done);

   always @(negedge clk) begin
      if (bus.alu_init === 1'b1) init_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                          input logic [5:0] exp_d, input logic exp_e, input int mul_lat, input int bp);
      int init0;
      init0 = init_cnt;
      @(negedge clk);
      chk("idle_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_op     = op;
      bus.res_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_a     = 3'($urandom);
      bus.in_b     = 3'($urandom);
      bus.in_op    = 2'($urandom);
      chk("busy_ready", 32'(bus.in_ready), 32'd0);
      chk("alu_a", 32'(bus.alu_a), 32'(a));
      chk("alu_b", 32'(bus.alu_b), 32'(b));
      chk("alu_op", 32'(bus.alu_op), 32'(op));
      if (op == 2'b10) begin
         chk("init_hi", 32'(bus.alu_init), 32'd1);
         chk("init_novalid", 32'(bus.res_valid), 32'd0);
         bus.alu_done = (mul_lat != 0);
         @(negedge clk);
         bus.alu_done = 1'b0;
         chk("init_lo", 32'(bus.alu_init), 32'd0);
         chk("early_done_ignored", 32'(bus.res_valid), 32'd0);
         for (int i = 0; i < mul_lat; i++) begin
            @(negedge clk);
            chk("mul_wait", 32'(bus.res_valid), 32'd0);
         end
         bus.alu_done = 1'b1;
         @(negedge clk);
         bus.alu_done = 1'b0;
      end else if (op != 2'b11) begin
         chk("exec_novalid", 32'(bus.res_valid), 32'd0);
         bus.alu_done = 1'($urandom);
         @(negedge clk);
         bus.alu_done = 1'b0;
      end
      chk("res_valid", 32'(bus.res_valid), 32'd1);
      chk("res_data", 32'(bus.res_data), 32'(exp_d));
      chk("res_err", 32'(bus.res_err), 32'(exp_e));
      chk("init_pulses", 32'(init_cnt - init0), (op == 2'b10) ? 32'd1 : 32'd0);
      for (int i = 0; i < bp; i++) begin
         bus.in_valid = 1'b1;
         bus.in_a     = 3'($urandom);
         bus.alu_done = 1'($urandom);
         @(negedge clk);
         chk("bp_valid", 32'(bus.res_valid), 32'd1);
         chk("bp_data", 32'(bus.res_data), 32'(exp_d));
         chk("bp_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.alu_done  = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a      = ~a;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("drain_valid", 32'(bus.res_valid), 32'd0);
      chk("drain_ready", 32'(bus.in_ready), 32'd1);
      chk("no_accept_on_drain", 32'(bus.alu_a), 32'(a));
   endtask

   task automatic chk_reset_vals();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
      chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
      chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
      chk("rst_init", 32'(bus.alu_init), 32'd0);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_res_data", 32'(bus.res_data), 32'd0);
      chk("rst_res_err", 32'(bus.res_err), 32'd0);
   endtask

   initial begin
      logic [2:0] ra, rb;
      logic [1:0] rop;
      n_vec         = 0;
      n_err         = 0;
      init_cnt      = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = 3'd0;
      bus.in_b      = 3'd0;
      bus.in_op     = 2'b00;
      bus.alu_done  = 1'b0;
      bus.res_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk_reset_vals();
      rst_n = 1'b1;

      // Directed cases.
      run_cmd(3'd3, 3'd2, 2'b00, 6'b000101, 1'b0, 0, 0);
      run_cmd(3'd2, 3'd3, 2'b01, 6'b111111, 1'b0, 0, 0);
      run_cmd(3'd3, 3'd3, 2'b10, 6'd9, 1'b0, 5, 0);
      run_cmd(3'd5, 3'd1, 2'b11, 6'd0, 1'b1, 0, 0);
      run_cmd(3'd7, 3'd7, 2'b00, 6'd14, 1'b0, 0, 10);
      run_cmd(3'd0, 3'd7, 2'b01, 6'b111001, 1'b0, 0, 1);
      run_cmd(3'd7, 3'd7, 2'b10, 6'd49, 1'b0, 0, 2);

      // Randomized commands against the arithmetic model.
      for (int n = 0; n < 24; n++) begin
         ra  = 3'($urandom);
         rb  = 3'($urandom);
         rop = 2'($urandom);
         run_cmd(ra, rb, rop, arith(ra, rb, rop), (rop == 2'b11), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)));
      end

      // Reset in the middle of a multiply wait.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 3'd5;
      bus.in_b     = 3'd6;
      bus.in_op    = 2'b10;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.alu_done = 1'b1;
      @(negedge clk);
      bus.alu_done = 1'b0;
      @(negedge clk);
      chk("late_done_valid", 32'(bus.res_valid), 32'd0);
      chk("late_done_data", 32'(bus.res_data), 32'd0);
      chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

`ifdef ALU_SEQ_TIMEOUT_EN
      // Multiply with no completion must time out after 8 cycles in MUL_WAIT.
      bus.in_valid = 1'b1;
      bus.in_a     = 3'd3;
      bus.in_b     = 3'd3;
      bus.in_op    = 2'b10;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("to_wait", 32'(bus.res_valid), 32'd0);
      end
      @(negedge clk);
      chk("to_valid", 32'(bus.res_valid), 32'd1);
      chk("to_data", 32'(bus.res_data), 32'd0);
      chk("to_err", 32'(bus.res_err), 32'd1);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("to_drain", 32'(bus.in_ready), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
